// File: rtl/dump_pkg.sv
// Shared types for the debug-unit state-dump sequencer.
// DUMP_CHECKSUM_EN adds the trailing checksum-byte states.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SEND       = 3'd2,
    ST_WAIT       = 3'd3,
    ST_NEXT       = 3'd4,
    ST_DONE       = 3'd5
`ifdef DUMP_CHECKSUM_EN
    ,
    ST_CKSUM_SEND = 3'd6,
    ST_CKSUM_WAIT = 3'd7
`endif
  } state_e;

  typedef enum logic [1:0] {
    PH_PC  = 2'd0,
    PH_REG = 2'd1,
    PH_MEM = 2'd2
  } phase_e;

  // Bytes per LEN-bit word.
  function automatic int unsigned bytes_per_word(input int unsigned len);
    return len / 8;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a LEN-bit word into bytes, LSB first, and flags the last byte.
// o_byte_c is the byte that will be at the head of the register next cycle.
module word_serializer
  import dump_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic [LEN-1:0] i_word,
  input  logic           i_shift,
  output logic [7:0]     o_byte_c,
  output logic           o_last_c
);

  localparam int unsigned NB    = bytes_per_word(LEN);
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [LEN-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_last_c = (cnt_q == CNT_W'(NB - 1));
  assign o_byte_c = shift_d[7:0];

  // Load restarts the byte count; each shift advances it and wraps after the last byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = '0;
    end else if (i_shift) begin
      shift_d = shift_q >> 8;
      cnt_d   = o_last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Dumps PC, register file and data memory over the UART TX byte interface.
// DUMP_CHECKSUM_EN appends an XOR checksum byte after the last memory word.
module debug_dump_ctrl
  import dump_pkg::*;
#(
  parameter int unsigned LEN      = 32,
  parameter int unsigned CANT_REG = 16,
  parameter int unsigned CANT_MEM = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [LEN-1:0]              i_pc,
  input  logic [LEN-1:0]              i_reg_data,
  input  logic [LEN-1:0]              i_mem_data,
  input  logic                        i_tx_done,
  output logic [$clog2(CANT_REG)-1:0] o_addr_reg,
  output logic [$clog2(CANT_MEM)-1:0] o_addr_mem,
  output logic                        o_tx_start,
  output logic [7:0]                  o_tx_data,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned AR_W = $clog2(CANT_REG);
  localparam int unsigned AM_W = $clog2(CANT_MEM);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [AR_W-1:0] addr_reg_q, addr_reg_d;
  logic [AM_W-1:0] addr_mem_q, addr_mem_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]      cksum_q, cksum_d;
`endif

  logic [LEN-1:0]  word_sel;
  logic            ser_load;
  logic            ser_shift;
  logic [7:0]      ser_byte_c;
  logic            ser_last_c;

  assign o_addr_reg = addr_reg_q;
  assign o_addr_mem = addr_mem_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

  always_comb begin
    case (phase_q)
      PH_REG:  word_sel = i_reg_data;
      PH_MEM:  word_sel = i_mem_data;
      default: word_sel = i_pc;
    endcase
  end

  assign ser_load  = (state_q == ST_LOAD);
  assign ser_shift = (state_q == ST_WAIT) && i_tx_done;

  word_serializer #(
    .LEN (LEN)
  ) u_ser (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (ser_load),
    .i_word   (word_sel),
    .i_shift  (ser_shift),
    .o_byte_c (ser_byte_c),
    .o_last_c (ser_last_c)
  );

  // Next state; the outgoing byte is captured on the transition into a send state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_reg_d = addr_reg_q;
    addr_mem_d = addr_mem_q;
    tx_data_d  = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          phase_d    = PH_PC;
          addr_reg_d = '0;
          addr_mem_d = '0;
`ifdef DUMP_CHECKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      ST_LOAD: begin
        tx_data_d = ser_byte_c;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
`ifdef DUMP_CHECKSUM_EN
        cksum_d = cksum_q ^ tx_data_q;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (ser_last_c) begin
            state_d = ST_NEXT;
          end else begin
            tx_data_d = ser_byte_c;
            state_d   = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        state_d = ST_LOAD;
        case (phase_q)
          PH_REG: begin
            if (addr_reg_q == AR_W'(CANT_REG - 1)) begin
              addr_reg_d = '0;
              addr_mem_d = '0;
              phase_d    = PH_MEM;
            end else begin
              addr_reg_d = addr_reg_q + AR_W'(1);
            end
          end
          PH_MEM: begin
            if (addr_mem_q == AM_W'(CANT_MEM - 1)) begin
              addr_mem_d = '0;
`ifdef DUMP_CHECKSUM_EN
              tx_data_d  = cksum_q;
              state_d    = ST_CKSUM_SEND;
`else
              state_d    = ST_DONE;
`endif
            end else begin
              addr_mem_d = addr_mem_q + AM_W'(1);
            end
          end
          default: begin
            phase_d    = PH_REG;
            addr_reg_d = '0;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef DUMP_CHECKSUM_EN
      ST_CKSUM_SEND: state_d = ST_CKSUM_WAIT;
      ST_CKSUM_WAIT: begin
        if (i_tx_done) begin
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef DUMP_CHECKSUM_EN
    tx_start_d = (state_d == ST_SEND) || (state_d == ST_CKSUM_SEND);
`else
    tx_start_d = (state_d == ST_SEND);
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_PC;
      addr_reg_q <= '0;
      addr_mem_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      addr_reg_q <= addr_reg_d;
      addr_mem_q <= addr_mem_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

endmodule
